// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: snake segment list, timed moves with collision checks, and per-pixel segment lookup
module snake_body_ctrl #(
   parameter int CELL        = 32,
   parameter int GRID_W      = 20,
   parameter int GRID_H      = 15,
   parameter int MAX_LEN     = 16,
   parameter int INIT_LEN    = 3,
   parameter int INIT_X      = 5,
   parameter int INIT_Y      = 7,
   parameter int MOVE_PERIOD = 4
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         frame_tick,
   input  logic [3:0]                   dir_req,
   input  logic                         grow,
   input  logic                         restart,
   input  logic [31:0]                  pxl_x,
   input  logic [31:0]                  pxl_y,
   output logic                         seg_hit,
   output logic [31:0]                  topLeft_x,
   output logic [31:0]                  topLeft_y,
   output logic [3:0]                   snake_direction,
   output logic [$clog2(GRID_W)-1:0]    head_x,
   output logic [$clog2(GRID_H)-1:0]    head_y,
   output logic [$clog2(MAX_LEN+1)-1:0] length,
   output logic                         collision,
   output logic                         busy
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int LW = $clog2(MAX_LEN+1);
   localparam int IW = $clog2(MAX_LEN);
   localparam int SH = $clog2(CELL);
   localparam int CW = $clog2(MOVE_PERIOD+1);

   typedef enum logic [2:0] {IDLE, STEP, CHECK, SHIFT, DEAD} state_t;
   state_t state, nxt;

   logic [XW-1:0]      seg_x [MAX_LEN];
   logic [YW-1:0]      seg_y [MAX_LEN];
   logic [XW-1:0]      init_x [MAX_LEN];
   logic [YW-1:0]      init_y [MAX_LEN];
   logic [LW-1:0]      len, last;
   logic [3:0]         cur_dir, pend_dir;
   logic               gp;
   logic [CW-1:0]      cnt;
   logic [IW-1:0]      idx;
   logic [XW-1:0]      nh_x, step_x;
   logic [YW-1:0]      nh_y, step_y;
   logic               wall, period_end, dir_ok, self_hit, restart_go, in_grid;
   logic [31:0]        cell_x, cell_y;
   logic [MAX_LEN-1:0] hitv;

   // starting body: head at INIT_X, remaining segments trailing to the left
   always_comb
      for (int i = 0; i < MAX_LEN; i++) begin
         init_x[i] = (i < INIT_LEN) ? XW'(INIT_X - i) : '0;
         init_y[i] = YW'(INIT_Y);
      end

   // next-head candidate, wall test, check bound and input qualifiers
   always_comb begin
      step_x     = pend_dir[0] ? seg_x[0] + 1'b1 : pend_dir[1] ? seg_x[0] - 1'b1 : seg_x[0];
      step_y     = pend_dir[2] ? seg_y[0] + 1'b1 : pend_dir[3] ? seg_y[0] - 1'b1 : seg_y[0];
      wall       = (pend_dir[3] && seg_y[0] == '0) || (pend_dir[2] && seg_y[0] == YW'(GRID_H-1)) ||
                   (pend_dir[1] && seg_x[0] == '0) || (pend_dir[0] && seg_x[0] == XW'(GRID_W-1));
      last       = gp ? len - 1'b1 : len - 2'd2;
      self_hit   = nh_x == seg_x[idx] && nh_y == seg_y[idx];
      period_end = frame_tick && cnt == CW'(MOVE_PERIOD-1);
      dir_ok     = $onehot(dir_req) && dir_req != {cur_dir[2], cur_dir[3], cur_dir[0], cur_dir[1]};
      restart_go = state == DEAD && restart;
   end

   // state register
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) state <= IDLE;
      else         state <= nxt;

   // next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = period_end ? STEP : IDLE;
         STEP:    nxt = wall ? DEAD : CHECK;
         CHECK:   nxt = self_hit ? DEAD : (LW'(idx) == last ? SHIFT : CHECK);
         SHIFT:   nxt = IDLE;
         DEAD:    nxt = restart ? IDLE : DEAD;
         default: nxt = IDLE;
      endcase
   end

   // segment list, direction, growth and frame counting; frozen while dead
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         seg_x    <= init_x;
         seg_y    <= init_y;
         len      <= LW'(INIT_LEN);
         cur_dir  <= 4'b0001;
         pend_dir <= 4'b0001;
         gp       <= 1'b0;
         cnt      <= '0;
         idx      <= '0;
         nh_x     <= '0;
         nh_y     <= '0;
      end else if (restart_go) begin
         seg_x    <= init_x;
         seg_y    <= init_y;
         len      <= LW'(INIT_LEN);
         cur_dir  <= 4'b0001;
         pend_dir <= 4'b0001;
         gp       <= 1'b0;
         cnt      <= '0;
         idx      <= '0;
      end else if (state != DEAD) begin
         if (dir_ok) pend_dir <= dir_req;
         gp <= state == SHIFT ? grow : gp | grow;
         if (state == IDLE && frame_tick) cnt <= period_end ? '0 : cnt + 1'b1;
         if (state == STEP) begin
            nh_x <= step_x;
            nh_y <= step_y;
            idx  <= '0;
         end
         if (state == CHECK) idx <= idx + 1'b1;
         if (state == SHIFT) begin
            for (int i = 1; i < MAX_LEN; i++) begin
               seg_x[i] <= seg_x[i-1];
               seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
            len      <= (gp && len < LW'(MAX_LEN)) ? len + 1'b1 : len;
            cur_dir  <= pend_dir;
         end
      end

   // parallel compare of the pixel's cell against every live segment
   always_comb begin
      cell_x  = pxl_x >> SH;
      cell_y  = pxl_y >> SH;
      in_grid = cell_x < 32'(GRID_W) && cell_y < 32'(GRID_H);
      for (int i = 0; i < MAX_LEN; i++)
         hitv[i] = in_grid && LW'(i) < len && seg_x[i] == cell_x[XW-1:0] && seg_y[i] == cell_y[YW-1:0];
   end

   // registered drawer outputs; corner and orientation hold on a miss
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         seg_hit         <= 1'b0;
         topLeft_x       <= '0;
         topLeft_y       <= '0;
         snake_direction <= 4'b0000;
      end else begin
         seg_hit <= |hitv;
         if (|hitv) begin
            topLeft_x       <= cell_x << SH;
            topLeft_y       <= cell_y << SH;
            snake_direction <= hitv[0] ? cur_dir : 4'b0000;
         end
      end

   assign head_x    = seg_x[0];
   assign head_y    = seg_y[0];
   assign length    = len;
   assign collision = state == DEAD;
   assign busy      = state == STEP || state == CHECK || state == SHIFT;
endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
- Owns the snake's segment list on the game grid and advances it once every MOVE_PERIOD frames, handling direction changes, growth, wall collisions and self-collisions.
- Time-shares the single snake sprite drawer across all segments. For the current VGA pixel it reports whether a segment covers it, plus the top-left corner and orientation code the drawer needs.
- Sits between the input/game-logic blocks and the snake drawer.

Parameters:
- CELL, 32: cell size in pixels, power of 2.
- GRID_W, 20: grid width in cells.
- GRID_H, 15: grid height in cells.
- MAX_LEN, 16: segment storage depth.
- INIT_LEN, 3: length after reset or restart.
- INIT_X, 5: head cell x after reset; the body extends to decreasing x.
- INIT_Y, 7: head cell y after reset.
- MOVE_PERIOD, 4: number of frame_tick pulses per move.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- frame_tick  in  1  one-cycle pulse per video frame
- dir_req  in  4  requested direction, one-hot: 1000 up, 0100 down, 0010 left, 0001 right
- grow  in  1  pulse: lengthen on next move
- restart  in  1  pulse: re-initialise, honoured only in DEAD
- pxl_x  in  32  current pixel x
- pxl_y  in  32  current pixel y
- seg_hit  out  1  current pixel lies inside a live segment cell
- topLeft_x  out  32  pixel x of the hit cell's top-left corner
- topLeft_y  out  32  pixel y of the hit cell's top-left corner
- snake_direction  out  4  orientation for the drawer
- head_x  out  $clog2(GRID_W)  head cell x
- head_y  out  $clog2(GRID_H)  head cell y
- length  out  $clog2(MAX_LEN+1)  live segment count
- collision  out  1  sticky; high in DEAD
- busy  out  1  high while a move is being evaluated

Behaviour:
- Reset: resetN, asynchronous, active-low; clock clk.
  - Resetting mid-move aborts the move with no partial update.
  - Segments take INIT values: seg[i] = (INIT_X-i, INIT_Y) for i < INIT_LEN.
  - length = INIT_LEN, committed direction = 0001, pending direction = 0001.
  - grow_pending = 0, frame counter = 0, state = IDLE.
  - Output reset values: seg_hit = 0, topLeft_x/y = 0, snake_direction = 0000, collision = 0, busy = 0.
- Direction capture (any state except DEAD):
  - A valid one-hot dir_req is latched into the pending direction.
  - dir_req = 0000 and non-one-hot values are ignored.
  - The exact reverse of the committed direction is ignored.
  - If several valid requests arrive before a move, the last one wins.
- grow sets grow_pending, which is sticky until consumed in SHIFT. A grow pulse in the same cycle as SHIFT is kept for the next move.
- State machine:
  - IDLE: on frame_tick, counter increments. At counter == MOVE_PERIOD-1, counter clears and the block goes to STEP. busy = 0 in IDLE, 1 in STEP/CHECK/SHIFT.
  - STEP (1 cycle): compute the new head = seg[0] stepped in the pending direction.
    - If x < 0, x >= GRID_W, y < 0 or y >= GRID_H, go to DEAD and set collision = 1.
    - Otherwise go to CHECK with idx = 0.
  - CHECK: compare the new head with seg[idx], one compare per cycle.
    - The last index checked is length-1 if grow_pending, else length-2 (the tail vacates its cell).
    - A match goes to DEAD with collision = 1; otherwise CHECK ends and the block goes to SHIFT.
  - SHIFT (1 cycle), all updates in that cycle:
    - seg[i+1] <= seg[i]; seg[0] <= new head.
    - If grow_pending: length <= min(length+1, MAX_LEN). At MAX_LEN the tail still drops.
    - Clear grow_pending; committed direction <= pending direction; return to IDLE.
    - frame_ticks arriving during STEP/CHECK/SHIFT are not counted.
  - DEAD: segments frozen; frame_tick, grow and dir_req are ignored. restart re-applies the reset values (except the async path) and goes to IDLE.
- Pixel lookup (every cycle, in all states):
  - cell_x = pxl_x >> log2(CELL), cell_y = pxl_y >> log2(CELL).
  - The cell is compared in parallel against seg[0..length-1]. Pixels outside the grid never hit.
  - Outputs are registered with 1-cycle latency:
    - seg_hit: 1 on a match.
    - topLeft_x = cell_x*CELL, topLeft_y = cell_y*CELL.
    - snake_direction = committed direction if seg[0] matched, else 0000 (body segments are drawn unrotated).
    - On a miss: seg_hit = 0, topLeft and snake_direction hold their previous values.
- Lookup always uses the registered segment array, so the array changes only on the SHIFT edge.
- head_x, head_y and length are driven directly from the registers.

Test Plan:
- Reset, then pxl (170,230) → one cycle later seg_hit = 1, topLeft = (160,224), snake_direction = 0001; pxl (100,230) → seg_hit = 1, direction 0000; pxl (60,230) → seg_hit = 0.
- 4 frame_ticks → busy high for 4 cycles (STEP, 2×CHECK, SHIFT), then head (6,7), length 3; cell (3,7) no longer hits; a 5th tick mid-busy is not counted.
- grow pulse, then 4 ticks → segments (7,7),(6,7),(5,7),(4,7), length 4; grow pulsed in the SHIFT cycle → length 5 after the following move.
- dir_req = 0010 while moving right → ignored, head (x+1,7); dir_req = 1000 → next head (x,6), snake_direction = 1000 on a head hit; dir_req = 0011 → ignored.
- Drive right until head x = 19, then one more move → collision = 1, state DEAD, head stays (19,7), ticks ignored; restart → head (5,7), length 3, collision = 0.
- Length 5, sequence up, left, down → new head equals seg[3] → collision = 1, no shift. Assert resetN low during CHECK → INIT state immediately, busy = 0.
